// File: rtl/my_axi4_lite_mst_if.sv
// AXI4-Lite channel bundle shared by the CSR master and its slaves.
`timescale 1ns/1ps
interface aix4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH = 32
);
    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic                        arvalid;
    logic                        arready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport mst_port (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slv_port (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/my_axi4_lite_mst.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response (data, resp code, saturating latency) back.
`timescale 1ns/1ps
module my_axi4_lite_mst #(
    parameter int ADDR_BIT_WIDTH    = 4,
    parameter int DATA_BIT_WIDTH    = 32,
    parameter int LAT_CNT_BIT_WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_sync_rst,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic                         i_cmd_is_wr,
    input  logic [ADDR_BIT_WIDTH-1:0]    i_cmd_addr,
    input  logic [DATA_BIT_WIDTH-1:0]    i_cmd_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0]  i_cmd_wstrb,
    output logic                         o_rsp_valid,
    input  logic                         i_rsp_ready,
    output logic                         o_rsp_is_wr,
    output logic [DATA_BIT_WIDTH-1:0]    o_rsp_rdata,
    output logic [1:0]                   o_rsp_resp,
    output logic [LAT_CNT_BIT_WIDTH-1:0] o_rsp_lat,
    aix4_lite_if.mst_port                if_m_axi4_lite
);

    localparam int STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;
    localparam logic [LAT_CNT_BIT_WIDTH-1:0] LAT_MAX = '1;
    localparam logic [LAT_CNT_BIT_WIDTH-1:0] LAT_ONE = LAT_CNT_BIT_WIDTH'(1);

    if ($bits(if_m_axi4_lite.awaddr) != ADDR_BIT_WIDTH) begin : g_addr_width_chk
        $error("my_axi4_lite_mst: ADDR_BIT_WIDTH differs from interface address width");
    end
    if ($bits(if_m_axi4_lite.wdata) != DATA_BIT_WIDTH) begin : g_data_width_chk
        $error("my_axi4_lite_mst: DATA_BIT_WIDTH differs from interface data width");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    typedef struct packed {
        logic                         cmd_ready;
        logic                         awvalid;
        logic                         wvalid;
        logic                         bready;
        logic                         arvalid;
        logic                         rready;
        logic [ADDR_BIT_WIDTH-1:0]    addr;
        logic [DATA_BIT_WIDTH-1:0]    wdata;
        logic [STRB_BIT_WIDTH-1:0]    wstrb;
        logic                         rsp_valid;
        logic                         rsp_is_wr;
        logic [DATA_BIT_WIDTH-1:0]    rsp_rdata;
        logic [1:0]                   rsp_resp;
        logic [LAT_CNT_BIT_WIDTH-1:0] lat;
    } regs_t;

    state_t state, state_nxt;
    regs_t  r, r_nxt;

    logic                         accept;
    logic                         aw_hs;
    logic                         w_hs;
    logic [LAT_CNT_BIT_WIDTH-1:0] lat_inc;

    assign accept  = i_cmd_valid && r.cmd_ready;
    assign aw_hs   = r.awvalid && if_m_axi4_lite.awready;
    assign w_hs    = r.wvalid && if_m_axi4_lite.wready;
    assign lat_inc = (r.lat == LAT_MAX) ? r.lat : r.lat + LAT_ONE;

    // NOTE: every field gets a default before the case so no path leaves a
    // variable unassigned -- that is what keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    r_nxt.addr      = i_cmd_addr;
                    r_nxt.rsp_is_wr = i_cmd_is_wr;
                    r_nxt.lat       = '0;
                    if (i_cmd_is_wr) begin
                        r_nxt.wdata   = i_cmd_wdata;
                        r_nxt.wstrb   = i_cmd_wstrb;
                        r_nxt.awvalid = 1'b1;
                        r_nxt.wvalid  = 1'b1;
                        state_nxt     = WR_AW_W;
                    end else begin
                        r_nxt.arvalid = 1'b1;
                        state_nxt     = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                r_nxt.lat = lat_inc;
                if (aw_hs) r_nxt.awvalid = 1'b0;
                if (w_hs)  r_nxt.wvalid  = 1'b0;
                // A channel is finished if it handshakes now or already did earlier.
                if ((aw_hs || !r.awvalid) && (w_hs || !r.wvalid)) begin
                    r_nxt.bready = 1'b1;
                    state_nxt    = WR_B;
                end
            end
            WR_B: begin
                r_nxt.lat = lat_inc;
                if (if_m_axi4_lite.bvalid && r.bready) begin
                    r_nxt.bready    = 1'b0;
                    r_nxt.rsp_resp  = if_m_axi4_lite.bresp;
                    r_nxt.rsp_rdata = '0;
                    r_nxt.rsp_valid = 1'b1;
                    state_nxt       = RSP;
                end
            end
            RD_AR: begin
                r_nxt.lat = lat_inc;
                if (r.arvalid && if_m_axi4_lite.arready) begin
                    r_nxt.arvalid = 1'b0;
                    r_nxt.rready  = 1'b1;
                    state_nxt     = RD_R;
                end
            end
            RD_R: begin
                r_nxt.lat = lat_inc;
                if (if_m_axi4_lite.rvalid && r.rready) begin
                    r_nxt.rready    = 1'b0;
                    r_nxt.rsp_resp  = if_m_axi4_lite.rresp;
                    r_nxt.rsp_rdata = if_m_axi4_lite.rdata;
                    r_nxt.rsp_valid = 1'b1;
                    state_nxt       = RSP;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    r_nxt.rsp_valid = 1'b0;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        r_nxt.cmd_ready = (state_nxt == IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            state <= IDLE;
            r     <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
        end
    end

    assign o_cmd_ready = r.cmd_ready;
    assign o_rsp_valid = r.rsp_valid;
    assign o_rsp_is_wr = r.rsp_is_wr;
    assign o_rsp_rdata = r.rsp_rdata;
    assign o_rsp_resp  = r.rsp_resp;
    assign o_rsp_lat   = r.lat;

    assign if_m_axi4_lite.awaddr  = r.addr;
    assign if_m_axi4_lite.awvalid = r.awvalid;
    assign if_m_axi4_lite.wdata   = r.wdata;
    assign if_m_axi4_lite.wstrb   = r.wstrb;
    assign if_m_axi4_lite.wvalid  = r.wvalid;
    assign if_m_axi4_lite.bready  = r.bready;
    assign if_m_axi4_lite.araddr  = r.addr;
    assign if_m_axi4_lite.arvalid = r.arvalid;
    assign if_m_axi4_lite.rready  = r.rready;

endmodule

// File: tb/tb_my_axi4_lite_mst.sv
// Bench for my_axi4_lite_mst: behavioural 4-register slave with programmable
// stalls and response codes, command-level memory model and bus monitor.
`timescale 1ns/1ps
module tb_my_axi4_lite_mst;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_is_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_is_wr;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [LW-1:0] rsp_lat;

    always #5 clk = ~clk;

    aix4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) axi ();

    my_axi4_lite_mst #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .LAT_CNT_BIT_WIDTH(LW)) dut (
        .i_clk(clk), .i_sync_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_is_wr(cmd_is_wr),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_is_wr(rsp_is_wr),
        .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_rsp_lat(rsp_lat),
        .if_m_axi4_lite(axi)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave behaviour knobs, set by the stimulus.
    int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] resp_code = 2'b00;

    // Bus monitor: handshake totals, timestamps and valid/payload stability.
    int            cyc = 0, viol = 0, acc_tot = 0, acc_cyc = 0, done_cyc = 0;
    int            aw_tot = 0, w_tot = 0, b_tot = 0, ar_tot = 0, r_tot = 0;
    logic [AW-1:0] aw_addr_l = '0, ar_addr_l = '0, p_awaddr = '0, p_araddr = '0;
    logic [DW-1:0] w_data_l = '0, p_wdata = '0;
    logic [3:0]    w_strb_l = '0, p_wstrb = '0;
    logic          p_awvalid = 1'b0, p_awready = 1'b0, p_wvalid = 1'b0, p_wready = 1'b0;
    logic          p_arvalid = 1'b0, p_arready = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            p_awvalid = 1'b0; p_wvalid = 1'b0; p_arvalid = 1'b0;
        end else begin
            if (p_awvalid && !p_awready && (axi.awvalid !== 1'b1 || axi.awaddr !== p_awaddr)) viol++;
            if (p_wvalid && !p_wready &&
                (axi.wvalid !== 1'b1 || axi.wdata !== p_wdata || axi.wstrb !== p_wstrb)) viol++;
            if (p_arvalid && !p_arready && (axi.arvalid !== 1'b1 || axi.araddr !== p_araddr)) viol++;
            if (cmd_valid && cmd_ready) begin acc_tot++; acc_cyc = cyc; end
            if (axi.awvalid && axi.awready) begin aw_tot++; aw_addr_l = axi.awaddr; end
            if (axi.wvalid && axi.wready) begin w_tot++; w_data_l = axi.wdata; w_strb_l = axi.wstrb; end
            if (axi.bvalid && axi.bready) begin b_tot++; done_cyc = cyc; end
            if (axi.arvalid && axi.arready) begin ar_tot++; ar_addr_l = axi.araddr; end
            if (axi.rvalid && axi.rready) begin r_tot++; done_cyc = cyc; end
            p_awvalid = axi.awvalid; p_awready = axi.awready; p_awaddr = axi.awaddr;
            p_wvalid  = axi.wvalid;  p_wready  = axi.wready;  p_wdata  = axi.wdata; p_wstrb = axi.wstrb;
            p_arvalid = axi.arvalid; p_arready = axi.arready; p_araddr = axi.araddr;
        end
        cyc++;
    end

    // Behavioural slave: drives its outputs on the falling edge.
    logic [DW-1:0] slave_mem [4] = '{default: '0};
    int            aw_used = 0, w_used = 0, b_used = 0, ar_used = 0, r_used = 0;
    int            aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit            have_aw = 0, have_w = 0, have_ar = 0;
    logic [DW-1:0] mask;

    always @(negedge clk) begin
        if (rst) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
            axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
            have_aw = 0; have_w = 0; have_ar = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            aw_used = aw_tot; w_used = w_tot; b_used = b_tot; ar_used = ar_tot; r_used = r_tot;
        end else begin
            if (aw_tot != aw_used) begin aw_used = aw_tot; have_aw = 1; end
            if (w_tot != w_used) begin w_used = w_tot; have_w = 1; end
            if (ar_tot != ar_used) begin ar_used = ar_tot; have_ar = 1; end

            if (axi.awready) axi.awready = 1'b0;
            else if (axi.awvalid && !have_aw) begin
                if (aw_wait >= aw_delay) begin axi.awready = 1'b1; aw_wait = 0; end
                else aw_wait++;
            end
            if (axi.wready) axi.wready = 1'b0;
            else if (axi.wvalid && !have_w) begin
                if (w_wait >= w_delay) begin axi.wready = 1'b1; w_wait = 0; end
                else w_wait++;
            end
            if (axi.arready) axi.arready = 1'b0;
            else if (axi.arvalid && !have_ar) begin
                if (ar_wait >= ar_delay) begin axi.arready = 1'b1; ar_wait = 0; end
                else ar_wait++;
            end

            if (b_tot != b_used) begin b_used = b_tot; axi.bvalid = 1'b0; end
            else if (have_aw && have_w && !axi.bvalid) begin
                if (b_wait >= b_delay) begin
                    if (resp_code == 2'b00) begin
                        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{w_strb_l[i]}};
                        slave_mem[aw_addr_l[3:2]] = (slave_mem[aw_addr_l[3:2]] & ~mask) | (w_data_l & mask);
                    end
                    axi.bresp = resp_code; axi.bvalid = 1'b1;
                    have_aw = 0; have_w = 0; b_wait = 0;
                end else b_wait++;
            end

            if (r_tot != r_used) begin r_used = r_tot; axi.rvalid = 1'b0; end
            else if (have_ar && !axi.rvalid) begin
                if (r_wait >= r_delay) begin
                    axi.rdata = (resp_code == 2'b00) ? slave_mem[ar_addr_l[3:2]] : '0;
                    axi.rresp = resp_code; axi.rvalid = 1'b1;
                    have_ar = 0; r_wait = 0;
                end else r_wait++;
            end
        end
    end

    // Command-level reference: register file contents as seen by software.
    logic [DW-1:0] ref_mem [4] = '{default: '0};

    task automatic run_txn(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [3:0] wstrb, input int hold, input string tag,
                           output logic [DW-1:0] got_rdata, output logic [1:0] got_resp,
                           output logic [LW-1:0] got_lat);
        int aw0 = aw_tot, w0 = w_tot, b0 = b_tot, ar0 = ar_tot, r0 = r_tot;
        int acc0 = acc_tot, viol0 = viol, n, d, hold_bad;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp = resp_code;
        logic [DW-1:0] s_rdata;
        logic [1:0]    s_resp;
        logic [LW-1:0] s_lat;
        logic          s_is_wr;

        if (is_wr) begin
            exp_rdata = '0;
            if (resp_code == 2'b00)
                for (int i = 0; i < 4; i++)
                    if (wstrb[i]) ref_mem[addr[3:2]][8*i +: 8] = wdata[8*i +: 8];
        end else begin
            exp_rdata = (resp_code == 2'b00) ? ref_mem[addr[3:2]] : '0;
        end

        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_is_wr = is_wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = AW'($urandom);

        n = 0;
        while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
        check({tag, "_rsp_valid"}, rsp_valid, 1);

        s_rdata = rsp_rdata; s_resp = rsp_resp; s_lat = rsp_lat; s_is_wr = rsp_is_wr;
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_is_wr = $urandom_range(0, 1);
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== s_rdata || rsp_resp !== s_resp || rsp_lat !== s_lat ||
                rsp_is_wr !== s_is_wr || cmd_ready || axi.awvalid || axi.wvalid || axi.arvalid)
                hold_bad++;
        end
        cmd_valid = 1'b0;
        if (hold > 0) check({tag, "_hold_stable"}, hold_bad, 0);

        d = done_cyc - acc_cyc;
        check({tag, "_is_wr"}, rsp_is_wr, is_wr);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_resp"}, rsp_resp, exp_resp);
        check({tag, "_lat"}, rsp_lat, (d > 255) ? 255 : d);
        check({tag, "_accepts"}, acc_tot - acc0, 1);
        check({tag, "_hs_counts"},
              {8'(aw_tot - aw0), 8'(w_tot - w0), 8'(b_tot - b0), 8'(ar_tot - ar0), 8'(r_tot - r0)},
              {8'(is_wr), 8'(is_wr), 8'(is_wr), 8'(!is_wr), 8'(!is_wr)});
        check({tag, "_stable_valid"}, viol - viol0, 0);
        got_rdata = rsp_rdata; got_resp = rsp_resp; got_lat = rsp_lat;

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_back_idle"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        logic [LW-1:0] lt;
        int            n;

        repeat (3) @(negedge clk);
        check("reset_ctrl", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                             rsp_valid, cmd_ready}, 7'b0);
        check("reset_data", {rsp_lat, rsp_resp, rsp_rdata, axi.awaddr, axi.wstrb}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);

        run_txn(1, 4'h4, 32'hDEADBEEF, 4'hF, 0, "wr4", rd, rs, lt);
        check("wr4_lat_min", lt, 2);
        run_txn(0, 4'h4, '0, 4'h0, 0, "rd4", rd, rs, lt);
        check("rd4_data_const", rd, 32'hDEADBEEF);
        check("rd4_lat_min", lt, 2);

        run_txn(1, 4'h8, 32'hFFFFFFFF, 4'hF, 0, "pre8", rd, rs, lt);
        run_txn(1, 4'h8, 32'h11223344, 4'b0101, 0, "wr8", rd, rs, lt);
        run_txn(0, 4'h8, '0, 4'h0, 0, "rd8", rd, rs, lt);
        check("rd8_data_const", rd, 32'hFF22FF44);

        aw_delay = 3; w_delay = 0;
        run_txn(1, 4'hC, 32'hA5A5_0001, 4'hF, 0, "w_first", rd, rs, lt);
        aw_delay = 0; w_delay = 3;
        run_txn(1, 4'hC, 32'hA5A5_0002, 4'hF, 0, "aw_first", rd, rs, lt);
        w_delay = 0;
        run_txn(1, 4'hC, 32'hA5A5_0003, 4'hF, 0, "aw_w_same", rd, rs, lt);

        resp_code = 2'b10;
        run_txn(0, 4'h0, '0, 4'h0, 0, "rd_slverr", rd, rs, lt);
        check("rd_slverr_resp_const", rs, 2'b10);
        resp_code = 2'b00;

        run_txn(1, 4'h0, 32'h0BAD_F00D, 4'hF, 5, "rsp_hold", rd, rs, lt);

        b_delay = 300;
        run_txn(1, 4'h4, 32'h1234_5678, 4'h3, 0, "lat_sat", rd, rs, lt);
        check("lat_sat_const", lt, 255);
        b_delay = 0;

        r_delay = 20;
        cmd_valid = 1'b1; cmd_is_wr = 1'b0; cmd_addr = 4'h4;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!axi.rready && n < 100) begin @(negedge clk); n++; end
        check("abort_in_rd_r", axi.rready, 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_during_rst", {axi.arvalid, axi.rready, rsp_valid, cmd_ready}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        check("abort_after_rst", {axi.arvalid, axi.rready, rsp_valid, cmd_ready}, 4'b0001);
        r_delay = 0;

        for (int t = 0; t < 40; t++) begin
            aw_delay  = $urandom_range(0, 4);
            w_delay   = $urandom_range(0, 4);
            b_delay   = $urandom_range(0, 4);
            ar_delay  = $urandom_range(0, 4);
            r_delay   = $urandom_range(0, 4);
            resp_code = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(1'($urandom_range(0, 1)), {2'($urandom_range(0, 3)), 2'b00}, $urandom,
                    4'($urandom), $urandom_range(0, 3), "rand", rd, rs, lt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
